inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, prefetch queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ready  input  1  memory completes the request this cycle.
REQ-008 imem_rdata  input  32  fetched word, valid when imem_req & imem_ready.
REQ-009 inst_valid  output  1  inst and inst_pc are valid for the core.
REQ-010 inst_ready  input  1  core consumes the instruction this cycle.
REQ-011 inst  output  32  instruction to the decode/control stage.
REQ-012 inst_pc  output  32  address of inst.
REQ-013 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc  input  32  new fetch target; bits[1:0] ignored (forced 0).
REQ-015 halted  input  1  core halted; stop issuing fetches.

Function
REQ-016 Memory handshake: once imem_req is high, imem_req and imem_addr SHALL stay stable until imem_ready is sampled high; the transfer completes in that cycle; latency 0..N cycles.
REQ-017 FSM states SHALL be IDLE, FETCH, DISCARD and HALT.
- IDLE->FETCH when the queue is not full and halted=0.
- FETCH->IDLE on completion with the queue now full.
- FETCH->DISCARD on redirect before completion.
- DISCARD->FETCH on completion (data dropped).
- Any->HALT when halted=1 and no request is pending; HALT is exited only by reset.
REQ-018 On completion in FETCH, {imem_addr, imem_rdata} SHALL be pushed into the queue, and fetch_pc SHALL advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-019 Consumer handshake: inst_valid = queue not empty; the head entry pops on inst_valid & inst_ready; inst/inst_pc SHALL hold stable while inst_valid & !inst_ready.
REQ-020 Latency: an empty queue with imem_ready high in the same cycle as the request SHALL give inst_valid on the next cycle.
REQ-021 Redirect SHALL have priority over every other event in the same cycle: the queue is flushed (including a same-cycle pop/push), fetch_pc <= {redirect_pc[31:2],2'b00}, and inst_valid=0 next cycle.
REQ-022 If a request is pending at redirect, it SHALL complete in DISCARD and its data SHALL never be pushed; the redirected fetch issues on the following cycle.
REQ-023 With the queue full, no request SHALL be issued; a simultaneous pop and push SHALL keep the occupancy unchanged.
REQ-024 While halted=1, no new request SHALL start; a pending request SHALL complete and be discarded.

Reset
REQ-025 On rst_b=0 (asynchronous): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, queue empty, state IDLE, fetch_pc=RESET_PC.
REQ-026 Reset asserted mid-request SHALL abandon the request immediately; the first request after release SHALL be RESET_PC.

Configuration
REQ-027 Macro FETCH_PREFETCH_EN: defined -> queue of FIFO_DEPTH entries, fetching ahead while not full; undefined -> single entry, and a fetch issues only when the queue is empty or popping; the handshake, redirect and reset behaviour SHALL be identical in both builds.

Structure
REQ-028 Package riscv_fetch_pkg SHALL hold the fetch_state_t enum, the fetch_entry_t struct {pc, inst}, NOP_INST=32'h0000_0013 and INST_BYTES=4.
REQ-029 Sub-module fetch_fifo (parameterized depth, push/pop/flush, full/empty) SHALL hold the queue; the FSM and PC logic live in inst_fetch_unit.

Verification
REQ-030 Reset release, imem_ready=1 constantly, inst_ready=1 -> imem_addr 0,4,8,... and inst_pc sequence 0,4,8 with inst_valid from cycle 2.
REQ-031 imem_ready high only every 3rd cycle -> imem_addr/imem_req held stable while waiting; no duplicate or lost inst_pc.
REQ-032 inst_ready=0 for 5 cycles (prefetch build) -> 2 entries queued, imem_req=0, inst stable; on release pcs continue without gap.
REQ-033 redirect_pc=32'h0000_0103 while a request to 0x10 is pending -> data for 0x10 dropped, next imem_addr=0x100, next inst_pc=0x100.
REQ-034 fetch_pc=32'hFFFF_FFFC -> next imem_addr=0x0.
REQ-035 halted=1 mid-request -> the request completes, then imem_req stays 0; rst_b pulse restarts fetching at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2,
      S_HALT    = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, inst} entries with push/pop/flush
// Flush wins over a same-cycle push or pop; the head is read combinationally.
module fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int           DEPTH       = 2,
   parameter fetch_entry_t RESET_ENTRY = '0,
   localparam int          CW          = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_entry_t  i_data,
   output fetch_entry_t  o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & (~o_full | i_pop) & ~i_flush;
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_ENTRY;
         end
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch FSM, PC sequencing and memory/core handshakes
// FETCH_PREFETCH_EN: defined -> FIFO_DEPTH-entry prefetch queue; undefined -> single entry.
module inst_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halted
);

`ifdef FETCH_PREFETCH_EN
   localparam int Q_DEPTH = FIFO_DEPTH;
`else
   // Single entry, never more than the configured queue.
   localparam int Q_DEPTH = (FIFO_DEPTH > 1) ? 1 : FIFO_DEPTH;
`endif
   localparam int           CW          = $clog2(Q_DEPTH + 1);
   localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, inst: NOP_INST};

   fetch_state_t  r_state;
   fetch_state_t  w_next_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_discard_addr;
   logic          r_pending;
   logic          w_complete;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_full_next;
   logic          w_room;
   logic [CW-1:0] w_count;
   logic [31:0]   w_redirect_target;
   fetch_entry_t  w_push_data;
   fetch_entry_t  w_head;

   // A request already on the bus must be held; only new ones are gated.
   assign imem_req   = (r_state == S_DISCARD) |
                       ((r_state == S_FETCH) & (r_pending | (~halted & ~redirect_valid)));
   assign imem_addr  = (r_state == S_DISCARD) ? r_discard_addr : r_fetch_pc;
   assign w_complete = imem_req & imem_ready;
   assign w_push     = (r_state == S_FETCH) & w_complete & ~redirect_valid & ~halted;
   assign w_pop      = inst_valid & inst_ready;
   assign inst_valid = ~w_empty;
   assign inst       = w_head.inst;
   assign inst_pc    = w_head.pc;
   assign w_room     = ~w_full | w_pop;
   assign w_push_data       = '{pc: imem_addr, inst: imem_rdata};
   assign w_redirect_target = redirect_pc & ~32'h0000_0003;

   always_comb begin
      w_full_next = w_full;
      if (w_push && !w_pop) begin
         w_full_next = (w_count == CW'(Q_DEPTH - 1));
      end else if (!w_push && w_pop) begin
         w_full_next = 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH       (Q_DEPTH),
      .RESET_ENTRY (RESET_ENTRY)
   ) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (halted)                        w_next_state = S_HALT;
            else if (redirect_valid || w_room) w_next_state = S_FETCH;
         end
         S_FETCH: begin
            if (!imem_req) begin
               if (halted) w_next_state = S_HALT;
            end else if (imem_ready) begin
               if (halted)              w_next_state = S_HALT;
               else if (redirect_valid) w_next_state = S_FETCH;
               else if (w_full_next)    w_next_state = S_IDLE;
            end else if (redirect_valid) begin
               w_next_state = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_ready) w_next_state = halted ? S_HALT : S_FETCH;
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state        <= S_IDLE;
         r_fetch_pc     <= RESET_PC;
         r_discard_addr <= RESET_PC;
         r_pending      <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_pending <= imem_req & ~imem_ready;
         // Freeze the abandoned address while DISCARD drains it.
         if (r_state != S_DISCARD) begin
            r_discard_addr <= r_fetch_pc;
         end
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
         end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + INST_BYTES;
         end
      end
   end

endmodule
